seg_scan_driver: RTL and testbench

Parameterised multiplexed seven-segment display driver. It time-scans DIGITS digit enables from the system clock, hex-decodes one 4-bit nibble per digit, and adds per-digit decimal point, forced blank and optional leading-zero blanking. It replaces the per-digit encoder plus external scan logic in the camera status display path. Input data is snapshotted once per frame, so a digit never shows a torn value.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 11 +
 rtl/seg_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg_scan_driver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// the unlit pattern and a constant-width helper.
package seg_pkg;

  // Active-high {g,f,e,d,c,b,a} glyphs, indexed by nibble value (entry 15 first).
  localparam logic [15:0][6:0] HEX_SEG_AH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [7:0] SEG_OFF_AH = 8'h00;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-high seven-segment glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_AH[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: per-frame input snapshot, guarded digit
// selects, hex decode with dp, forced blank and optional leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS          = 6,
  parameter int CLK_DIV         = 50000,
  parameter int GUARD           = 2,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SEL_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LEAD_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   sel,
  output logic [7:0]          seg,
  output logic                frame_start
);

  localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam int DIV_W = clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0]  GUARD_END = DIV_W'(GUARD);
  localparam logic [DIGITS-1:0] SEL_OFF   = {DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF   = SEG_OFF_AH ^ {8{SEG_ACTIVE_LOW}};

  logic [DIV_W-1:0]    divCnt_q, divCnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snapData_q;
  logic [DIGITS-1:0]   snapDp_q, snapBlank_q;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                frameStart_q, frameStart_d;
  logic                loadSnap;

  logic [DIGITS-1:0]   leadZero;
  logic                allZero;
  logic [3:0]          curNibble;
  logic                curDp, curBlank, curLead;
  logic [6:0]          hexAh;
  logic [DIGITS-1:0]   selAh;

  // leadZero[k] is set when nibbles k..DIGITS-1 of the snapshot are all zero.
  always_comb begin
    leadZero = '0;
    allZero  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      allZero     = allZero && (snapData_q[4*k +: 4] == 4'h0);
      leadZero[k] = allZero;
    end
  end

  always_comb begin
    curNibble = 4'h0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    curLead   = 1'b0;
    selAh     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        curNibble = snapData_q[4*k +: 4];
        curDp     = snapDp_q[k];
        curBlank  = snapBlank_q[k];
        curLead   = leadZero[k] && (k != 0);
        selAh[k]  = 1'b1;
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble_i (curNibble),
    .seg_o    (hexAh)
  );

  // Prescaler/index advance and the registered-output next values.
  always_comb begin
    divCnt_d     = divCnt_q;
    idx_d        = idx_q;
    loadSnap     = 1'b0;
    frameStart_d = 1'b0;
    sel_d        = SEL_OFF;
    seg_d        = SEG_OFF;
    if (!en) begin
      divCnt_d = '0;
      idx_d    = '0;
      loadSnap = 1'b1;
    end else begin
      if (divCnt_q == DIV_LAST) begin
        divCnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d        = '0;
          loadSnap     = 1'b1;
          frameStart_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        divCnt_d = divCnt_q + 1'b1;
      end
      if (divCnt_q >= GUARD_END) sel_d = selAh ^ SEL_OFF;
      if (curBlank || (BLANK_LEAD_ZERO && curLead)) seg_d = SEG_OFF;
      else seg_d = {curDp, hexAh} ^ {8{SEG_ACTIVE_LOW}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q     <= '0;
      idx_q        <= '0;
      snapData_q   <= '0;
      snapDp_q     <= '0;
      snapBlank_q  <= '0;
      sel_q        <= SEL_OFF;
      seg_q        <= SEG_OFF;
      frameStart_q <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frameStart_q <= frameStart_d;
      if (loadSnap) begin
        snapData_q  <= data;
        snapDp_q    <= dp;
        snapBlank_q <= blank;
      end
    end
  end

  assign sel         = sel_q;
  assign seg         = seg_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: two instances (leading-zero blanking off/on)
// driven from the same inputs with hand-computed expected patterns.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] data;
  logic [5:0]  dp, blank;
  logic [5:0]  sel1, sel2;
  logic [7:0]  seg1, seg2;
  logic        fs1, fs2;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(6), .CLK_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .BLANK_LEAD_ZERO(1'b0)
  ) dutPlain (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
    .sel(sel1), .seg(seg1), .frame_start(fs1)
  );

  seg_scan_driver #(
    .DIGITS(6), .CLK_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .BLANK_LEAD_ZERO(1'b1)
  ) dutLead (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
    .sel(sel2), .seg(seg2), .frame_start(fs2)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b);
    data  = d;
    dp    = p;
    blank = b;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " sel1"}, {2'b00, sel1}, 8'h3F);
    checkOutput({tag, " seg1"}, seg1, 8'hFF);
    checkOutput({tag, " fs1"}, {7'd0, fs1}, 8'h00);
    checkOutput({tag, " sel2"}, {2'b00, sel2}, 8'h3F);
    checkOutput({tag, " seg2"}, seg2, 8'hFF);
    checkOutput({tag, " fs2"}, {7'd0, fs2}, 8'h00);
  endtask

  // Each slot is 4 output cycles; first is the guard cycle with all selects off.
  task automatic checkFrame(input logic [5:0][7:0] exp1, input logic [5:0][7:0] exp2,
                            input int fromSlot, input int toSlot);
    logic [5:0] selExp;
    logic       fsExp;
    for (int k = fromSlot; k <= toSlot; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(posedge clk);
        #1;
        selExp = (j == 0) ? 6'h3F : ~(6'b000001 << k);
        fsExp  = (k == 5) && (j == 3);
        checkOutput($sformatf("sel1 d%0d c%0d", k, j), {2'b00, sel1}, {2'b00, selExp});
        checkOutput($sformatf("seg1 d%0d c%0d", k, j), seg1, exp1[k]);
        checkOutput($sformatf("fs1 d%0d c%0d", k, j), {7'd0, fs1}, {7'd0, fsExp});
        checkOutput($sformatf("sel2 d%0d c%0d", k, j), {2'b00, sel2}, {2'b00, selExp});
        checkOutput($sformatf("seg2 d%0d c%0d", k, j), seg2, exp2[k]);
      end
    end
  endtask

  localparam logic [5:0][7:0] F_543210 = {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  localparam logic [5:0][7:0] F_FEDCBA = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
  localparam logic [5:0][7:0] F_DPBLK  = {8'hFF, 8'h99, 8'hB0, 8'h24, 8'hF9, 8'hC0};
  localparam logic [5:0][7:0] F_102    = {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hA4};
  localparam logic [5:0][7:0] F_102LZ  = {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hA4};
  localparam logic [5:0][7:0] F_ZERO   = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  localparam logic [5:0][7:0] F_ZEROLZ = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    applyStimulus(24'h543210, 6'b0, 6'b0);
    #2 rst_n = 1'b0;
    #1 checkIdle("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 checkIdle("idle en0");
    end

    en = 1'b1;
    checkFrame(F_543210, F_543210, 0, 2);
    applyStimulus(24'hFEDCBA, 6'b0, 6'b0);
    checkFrame(F_543210, F_543210, 3, 5);

    applyStimulus(24'h543210, 6'b000100, 6'b100000);
    checkFrame(F_FEDCBA, F_FEDCBA, 0, 5);

    applyStimulus(24'h000102, 6'b0, 6'b0);
    checkFrame(F_DPBLK, F_DPBLK, 0, 5);

    applyStimulus(24'h000000, 6'b0, 6'b0);
    checkFrame(F_102, F_102LZ, 0, 5);

    applyStimulus(24'h999999, 6'b0, 6'b0);
    checkFrame(F_ZERO, F_ZEROLZ, 0, 5);

    repeat (14) @(posedge clk);
    #1 checkOutput("pre-reset sel1", {2'b00, sel1}, 8'h37);
    rst_n = 1'b0;
    #1 checkIdle("async reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 checkIdle("held reset");
    end
    rst_n = 1'b1;
    checkFrame(F_ZERO, F_ZEROLZ, 0, 5);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
